// File: rtl/debounce_bank_if.sv
// Pin-side / control-side bundle for debounce_bank.
// master = the debouncer (consumes raw pins, drives clean signals); slave = GPIO/control logic.
interface debounce_bank_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_sw;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_rise;
  logic [NUM_CH-1:0] o_fall;
  logic              o_any_event;
  logic [NUM_CH-1:0] o_hold;

  modport master (
    input  i_sw,
    output o_level, o_rise, o_fall, o_any_event, o_hold
  );

  modport slave (
    output i_sw,
    input  o_level, o_rise, o_fall, o_any_event, o_hold
  );
endinterface

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: 2-FF sync, per-channel polarity, saturating stability counter.
// Define HOLD_DETECT_EN to add per-channel long-press (o_hold) detection.
module debounce_ch #(
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b0
`ifdef HOLD_DETECT_EN
  , parameter int HOLD_CYCLES = 1000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic evt_d
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic [1:0]    sync;
  logic          s;
  logic          done;
  logic [CW-1:0] cnt;

  // Sync stages reset to the idle raw level so release of reset is event-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{ACTIVE_LOW}};
    else        sync <= {sync[0], sw};
  end

  assign s     = sync[1] ^ ACTIVE_LOW;
  assign done  = (s != level) && (cnt == CW'(STABLE_CYCLES - 1));
  assign evt_d = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= done & s;
      fall <= done & ~s;
      if (s == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef HOLD_DETECT_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] h;

  // Saturating at HOLD_CYCLES gives exactly one pulse per press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h    <= '0;
      hold <= 1'b0;
    end else begin
      hold <= level && (h == HW'(HOLD_CYCLES - 1));
      if (!level)                     h <= '0;
      else if (h != HW'(HOLD_CYCLES)) h <= h + 1'b1;
    end
  end
`else
  assign hold = 1'b0;
`endif
endmodule

module debounce_bank #(
  parameter int                NUM_CH          = 4,
  parameter int                STABLE_CYCLES   = 16,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b0}},
  parameter int                HOLD_CYCLES     = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  debounce_bank_if.master  bus
);
  logic [NUM_CH-1:0] level, rise, fall, hold, evt_d;
  logic              any_event;

  if (NUM_CH < 1 || NUM_CH > 32 || STABLE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_cfg_err
    $error("debounce_bank: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW_MASK[i])
`ifdef HOLD_DETECT_EN
      , .HOLD_CYCLES (HOLD_CYCLES)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (bus.i_sw[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .hold  (hold[i]),
      .evt_d (evt_d[i])
    );
  end

  // Registered from the same next-state terms as the pulses, so it lines up with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_event <= 1'b0;
    else        any_event <= |evt_d;
  end

  assign bus.o_level     = level;
  assign bus.o_rise      = rise;
  assign bus.o_fall      = fall;
  assign bus.o_hold      = hold;
  assign bus.o_any_event = any_event;
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: NUM_CH=4, STABLE_CYCLES=8, mask 4'b0010, HOLD_CYCLES=32.
module tb_debounce_bank;
`ifdef HOLD_DETECT_EN
  localparam int HOLD_ON = 1;
`else
  localparam int HOLD_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   inv_err = 0;
  int   rise_cnt [4];
  int   fall_cnt [4];
  int   hold_cnt [4];
  int   any_cnt = 0;
  int   r0, a0, h0;

  debounce_bank_if #(.NUM_CH(4)) bus ();

  debounce_bank #(
    .NUM_CH          (4),
    .STABLE_CYCLES   (8),
    .ACTIVE_LOW_MASK (4'b0010),
    .HOLD_CYCLES     (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        rise_cnt[c] += int'(bus.o_rise[c]);
        fall_cnt[c] += int'(bus.o_fall[c]);
        hold_cnt[c] += int'(bus.o_hold[c]);
      end
      any_cnt += int'(bus.o_any_event);
      if ((bus.o_rise & bus.o_fall) != 4'b0 || bus.o_any_event !== |(bus.o_rise | bus.o_fall))
        inv_err++;
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
    end
    bus.i_sw = 4'b0010;

    // Reset state and quiet release
    tick(2);
    chk("rst_level", 32'(bus.o_level), 32'h0);
    chk("rst_pulses", 32'({bus.o_rise, bus.o_fall, bus.o_hold}), 32'h0);
    chk("rst_any", 32'(bus.o_any_event), 32'h0);
    rst_n = 1'b1;
    tick(50);
    chk("idle_level", 32'(bus.o_level), 32'h0);
    chk("idle_rises", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 32'h0);
    chk("idle_falls", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'h0);
    chk("idle_any", 32'(any_cnt), 32'h0);

    // Clean step on ch0: level changes on edge 10
    bus.i_sw = 4'b0011;
    tick(9);
    chk("step_e9_level", 32'(bus.o_level), 32'h0);
    tick(1);
    chk("step_e10_level", 32'(bus.o_level), 32'h1);
    chk("step_e10_rise", 32'(bus.o_rise), 32'h1);
    chk("step_e10_any", 32'(bus.o_any_event), 32'h1);
    tick(1);
    chk("step_e11_rise", 32'(bus.o_rise), 32'h0);
    chk("step_e11_any", 32'(bus.o_any_event), 32'h0);
    bus.i_sw = 4'b0010;
    tick(9);
    chk("fall_e9_level", 32'(bus.o_level), 32'h1);
    tick(1);
    chk("fall_e10_level", 32'(bus.o_level), 32'h0);
    chk("fall_e10_fall", 32'(bus.o_fall), 32'h1);
    tick(1);
    chk("fall_e11_fall", 32'(bus.o_fall), 32'h0);
    chk("ch0_rise_total", 32'(rise_cnt[0]), 32'd1);

    // Bouncing ch2 then settle high
    r0 = rise_cnt[2];
    for (int b = 0; b < 2; b++) begin
      bus.i_sw = 4'b0110; tick(3);
      bus.i_sw = 4'b0010; tick(3);
    end
    chk("bounce_level", 32'(bus.o_level), 32'h0);
    chk("bounce_rises", 32'(rise_cnt[2] - r0), 32'h0);
    bus.i_sw = 4'b0110;
    tick(9);
    chk("settle_e9_level", 32'(bus.o_level), 32'h0);
    tick(1);
    chk("settle_e10_level", 32'(bus.o_level), 32'h4);
    chk("settle_e10_rise", 32'(bus.o_rise), 32'h4);
    tick(5);
    chk("settle_one_rise", 32'(rise_cnt[2] - r0), 32'd1);

    // Simultaneous press: ch1 (active-low) and ch3
    a0 = any_cnt;
    bus.i_sw = 4'b1100;
    tick(9);
    chk("dual_e9_level", 32'(bus.o_level), 32'h4);
    tick(1);
    chk("dual_e10_rise", 32'(bus.o_rise), 32'ha);
    chk("dual_e10_level", 32'(bus.o_level), 32'he);
    tick(3);
    chk("dual_any_cycles", 32'(any_cnt - a0), 32'd1);

    // Release all three together
    bus.i_sw = 4'b0010;
    tick(10);
    chk("rel_fall", 32'(bus.o_fall), 32'he);
    tick(2);
    chk("rel_level", 32'(bus.o_level), 32'h0);

    // Reset mid-count on ch0 (cnt=5 after edge 7)
    r0 = rise_cnt[0];
    a0 = any_cnt;
    bus.i_sw = 4'b0011;
    tick(7);
    rst_n = 1'b0;
    bus.i_sw = 4'b0010;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("midrst_level", 32'(bus.o_level), 32'h0);
    chk("midrst_rise", 32'(rise_cnt[0] - r0), 32'h0);
    chk("midrst_any", 32'(any_cnt - a0), 32'h0);

    // Long press on ch0: hold pulse 32 edges after level rises
    h0 = hold_cnt[0];
    bus.i_sw = 4'b0011;
    tick(10);
    chk("hold_level", 32'(bus.o_level), 32'h1);
    tick(31);
    chk("hold_early", 32'(hold_cnt[0] - h0), 32'h0);
    tick(1);
    chk("hold_pulse", 32'(bus.o_hold), 32'(HOLD_ON));
    tick(1);
    chk("hold_after", 32'(bus.o_hold), 32'h0);
    tick(40);
    chk("hold_once", 32'(hold_cnt[0] - h0), 32'(HOLD_ON));
    bus.i_sw = 4'b0010;
    tick(12);
    chk("hold_rel_level", 32'(bus.o_level), 32'h0);
    bus.i_sw = 4'b0011;
    tick(42);
    chk("hold_rearm", 32'(hold_cnt[0] - h0), 32'(2 * HOLD_ON));
    tick(5);
    chk("hold_total", 32'(hold_cnt[0] + hold_cnt[1] + hold_cnt[2] + hold_cnt[3] - h0),
        32'(2 * HOLD_ON));

    chk("invariants", 32'(inv_err), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel successor to the single-switch debouncer.
- Debounces N asynchronous switch/button inputs. Each channel has a 2-FF synchroniser, per-channel polarity and a saturating stability counter.
- Outputs per channel: clean level, rise/fall pulses, and an optional long-press pulse.
- Sits between board pins and the memory-mapped GPIO/control logic of the RV32I SoC.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- STABLE_CYCLES, 16, consecutive synchronised samples that must differ from o_level before it changes (>=2).
- ACTIVE_LOW_MASK, {NUM_CH{1'b0}}, bit i=1 means channel i is pulled up / active-low (logical = raw inverted).
- HOLD_CYCLES, 1000000, cycles o_level must stay 1 before o_hold pulses (used only with HOLD_DETECT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_sw  in  NUM_CH  raw asynchronous switch inputs.
- o_level  out  NUM_CH  debounced logical level (1 = pressed/active).
- o_rise  out  NUM_CH  1-cycle pulse when o_level goes 0->1.
- o_fall  out  NUM_CH  1-cycle pulse when o_level goes 1->0.
- o_any_event  out  1  OR of all o_rise and o_fall bits (registered, same cycle).
- o_hold  out  NUM_CH  1-cycle long-press pulse (0 when feature disabled).

Behaviour:
- Reset:
  - Sync FF bits load ACTIVE_LOW_MASK, i.e. the idle raw level, so no spurious event follows reset release.
  - o_level, o_rise, o_fall, o_any_event, o_hold = 0; all counters = 0.
- Synchroniser: 2 FF stages per channel. Logical sample s[i] = sync2[i] XOR ACTIVE_LOW_MASK[i].
- Counter cnt[i], width $clog2(STABLE_CYCLES):
  - s[i]==o_level[i]: cnt <= 0 (any bounce restarts the window).
  - s[i]!=o_level[i] and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s[i]!=o_level[i] and cnt == STABLE_CYCLES-1: o_level[i] <= s[i], cnt <= 0, and o_rise[i] or o_fall[i] is asserted in the same cycle o_level updates.
- Latency: a clean input step is first captured on edge 1. o_level changes on rising edge STABLE_CYCLES+2 counted from that edge.
- A glitch shorter than STABLE_CYCLES sampled cycles never reaches o_level and produces no pulses.
- o_rise, o_fall and o_hold are high for exactly one cycle. Rise and fall on the same channel can never coincide. Different channels are fully independent and may pulse in the same cycle.
- o_any_event is registered alongside the pulses (no extra latency).
- Asynchronous reset mid-count discards any pending change. No event is emitted afterwards unless the input is still active.
- Counters never wrap: the maximum value reached is STABLE_CYCLES-1.

Optional Feature:
- Macro HOLD_DETECT_EN.
- Defined:
  - Each channel has a hold counter h[i], width $clog2(HOLD_CYCLES+1), cleared while o_level[i]==0.
  - h[i] increments every cycle o_level[i]==1 and saturates at HOLD_CYCLES.
  - o_hold[i] pulses for 1 cycle on the cycle h[i] first reaches HOLD_CYCLES; only one pulse per press.
  - Release, then re-press, re-arms the pulse.
- Undefined: no hold counters are instantiated and o_hold is tied to 0. The port list is unchanged.

Test Plan:
- Common configuration: NUM_CH=4, STABLE_CYCLES=8, ACTIVE_LOW_MASK=4'b0010, HOLD_CYCLES=32.
- Reset release with i_sw=4'b0010 idle, held 50 cycles -> o_level=0, no o_rise/o_fall/o_any_event pulses.
- i_sw[0] steps 0->1 cleanly -> o_level[0]=1 on edge 10 after first capture, with a single-cycle o_rise[0] and o_any_event in the same cycle. Stepping back gives o_fall[0] with the same latency.
- i_sw[2] bounces 1,0,1,0 at 3-cycle intervals, then holds 1 -> no change during bouncing; o_level[2] rises 10 edges after the final transition is captured, with exactly one o_rise[2].
- i_sw[1] driven 1->0 (active-low press) -> o_level[1]=1 and o_rise[1]. Simultaneously, i_sw[3] pressed on the same cycle -> o_rise[1] and o_rise[3] both asserted in the same cycle, with one o_any_event cycle.
- rst_n pulsed low when cnt[0]=5 on a pending press, then released with the input returned idle -> o_level[0] stays 0 and no pulse is emitted.
- HOLD_DETECT_EN defined, i_sw[0] held 1 -> o_hold[0] pulses once, 32 cycles after o_level[0] rises, with no further pulses. Release and re-press -> a second pulse. Without the macro, o_hold stays 0 throughout.
